// File: rtl/pwm_pkg.sv
// pwm_pkg: PWM code width shared with the generator and the capture FSM states.
package pwm_pkg;
  localparam int PWM_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer plus delay flop for an async PWM input, with edge strobes.
module sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic i_in,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);
  logic r_s1, r_s2, r_sd;
  always_ff @(posedge clock)
    if (!reset) {r_s1, r_s2, r_sd} <= '0;
    else {r_s1, r_s2, r_sd} <= {i_in, r_s1, r_s2};
  assign o_s = r_s2;
  assign o_rise = r_s2 & ~r_sd;
  assign o_fall = ~r_s2 & r_sd;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period and high time, reported as generator T/duty codes.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic             io_in,
  output logic [WIDTH-1:0] io_T,
  output logic [WIDTH-1:0] io_duty,
  output logic             io_valid,
  output logic             io_overflow,
  output logic             io_busy
);
  localparam logic [WIDTH:0] CNT_MAX = {1'b1, {WIDTH{1'b0}}};
  state_t r_state, w_next;
  logic [WIDTH:0] r_cnt, r_hcnt;
  logic w_s, w_rise, w_fall, w_ovf;
  sync_edge u_sync (
    .clock (clock),
    .reset (reset),
    .i_in  (io_in),
    .o_s   (w_s),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );
  // A rise landing on the last legal count closes the period, so it beats overflow.
  assign w_ovf = r_cnt == CNT_MAX && !w_rise;
  always_ff @(posedge clock)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = !io_en ? IDLE :
             r_state == IDLE ? ARM :
             r_state == ARM && w_rise ? MEASURE :
             r_state == MEASURE && w_ovf ? ARM : r_state;
  always_comb io_busy = r_state == MEASURE;
  always_ff @(posedge clock)
    if (!reset) begin
      r_cnt <= '0;
      r_hcnt <= '0;
      io_T <= '0;
      io_duty <= '0;
      io_valid <= 1'b0;
      io_overflow <= 1'b0;
    end else begin
      io_valid <= 1'b0;
      if (!io_en || r_state == IDLE) r_cnt <= '0;
      else if (w_rise) begin
        r_cnt <= (WIDTH+1)'(1);
        if (r_state == MEASURE) begin
          io_T <= WIDTH'(r_cnt - 1'b1);
          io_duty <= WIDTH'(r_hcnt - 1'b1);
          io_valid <= 1'b1;
          io_overflow <= 1'b0;
        end
      end else if (r_state == MEASURE) begin
        r_cnt <= w_ovf ? '0 : r_cnt + 1'b1;
        io_overflow <= io_overflow | w_ovf;
        if (w_fall && w_s == 1'b0) r_hcnt <= r_cnt;
      end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random PWM streams against a period-list reference model with a valid-driven scoreboard.
module tb_pwm_capture;
  import pwm_pkg::*;
  localparam int W = PWM_WIDTH;
  typedef struct {
    int t;
    int d;
    int g;
  } exp_t;
  logic clock = 0, reset = 0, io_en = 0, io_in = 0;
  logic [W-1:0] io_T, io_duty;
  logic io_valid, io_overflow, io_busy;
  exp_t q[$];
  exp_t m_e;
  int checks = 0, errors = 0, cyc_n = 0, last_v = 0;

  pwm_capture #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_en      (io_en),
    .io_in      (io_in),
    .io_T       (io_T),
    .io_duty    (io_duty),
    .io_valid   (io_valid),
    .io_overflow(io_overflow),
    .io_busy    (io_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc_n++;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  always @(negedge clock)
    if (reset && io_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got T=%0d duty=%0d expected no valid", io_T, io_duty);
      end else begin
        m_e = q.pop_front();
        chk("T", int'(io_T), m_e.t);
        chk("duty", int'(io_duty), m_e.d);
        chk("ovf_at_valid", int'(io_overflow), 0);
        chk("duty_lt_T", int'(io_duty < io_T), 1);
        if (m_e.g != 0) chk("valid_gap", cyc_n - last_v, m_e.g);
      end
      last_v = cyc_n;
    end

  task automatic cyc(input logic v);
    io_in = v;
    @(posedge clock);
    #1;
  endtask

  task automatic rearm();
    repeat (4) cyc(0);
    io_en = 0;
    cyc(0);
    io_en = 1;
    cyc(0);
  endtask

  // Each complete period between two rises seen while armed yields (P-1, H-1).
  task automatic run_stream(input int n, input int pmin, input int pmax, input int hfix, input bit brk);
    int p, h;
    rearm();
    if (brk) begin
      cyc(1);
      cyc(1);
      cyc(0);
      io_en = 0;
      cyc(0);
      chk("busy_en_drop", int'(io_busy), 0);
      io_en = 1;
      cyc(0);
      cyc(0);
    end
    for (int i = 0; i < n; i++) begin
      p = $urandom_range(pmax, pmin);
      h = hfix != 0 ? hfix : $urandom_range(p - 1, 1);
      q.push_back('{p - 1, h - 1, i == 0 ? 0 : p});
      repeat (h) cyc(1);
      repeat (p - h) cyc(0);
    end
    cyc(1);
    repeat (8) cyc(0);
    chk("drain", q.size(), 0);
    chk("busy_measure", int'(io_busy), 1);
  endtask

  initial begin
    repeat (3) cyc(0);
    chk("rst_T", int'(io_T), 0);
    chk("rst_duty", int'(io_duty), 0);
    chk("rst_valid", int'(io_valid), 0);
    chk("rst_ovf", int'(io_overflow), 0);
    chk("rst_busy", int'(io_busy), 0);
    reset = 1;
    io_en = 1;
    run_stream(6, 8, 8, 3, 0);
    chk("ovf_loopback", int'(io_overflow), 0);
    run_stream(8, 2, 2, 1, 0);
    run_stream(20, 2, 40, 0, 0);
    run_stream(2, 256, 256, 255, 0);
    chk("ovf_max_period", int'(io_overflow), 0);
    rearm();
    cyc(1);
    cyc(1);
    repeat (300) cyc(0);
    chk("ovf_hold_low", int'(io_overflow), 1);
    chk("busy_after_ovf", int'(io_busy), 0);
    run_stream(4, 4, 4, 2, 0);
    chk("ovf_clear_low", int'(io_overflow), 0);
    rearm();
    repeat (300) cyc(1);
    chk("ovf_hold_high", int'(io_overflow), 1);
    run_stream(3, 4, 4, 2, 0);
    chk("ovf_clear_high", int'(io_overflow), 0);
    run_stream(3, 6, 6, 2, 1);
    reset = 0;
    cyc(0);
    chk("mid_rst_T", int'(io_T), 0);
    chk("mid_rst_duty", int'(io_duty), 0);
    chk("mid_rst_valid", int'(io_valid), 0);
    chk("mid_rst_ovf", int'(io_overflow), 0);
    chk("mid_rst_busy", int'(io_busy), 0);
    reset = 1;
    run_stream(5, 3, 12, 0, 0);
    chk("final_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
